apb_slave_memory: RTL and testbench



---
 rtl/apb_slave_memory_pkg.sv | 15 +
 rtl/apb_slave_memory_if.sv | 30 +++
 rtl/apb_mem_bytelane_ram.sv | 40 ++++
 rtl/apb_slave_memory.sv | 105 ++++++++++
 tb/tb_apb_slave_memory.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_memory_pkg.sv
// Shared types and constants for the APB4 slave memory.
package apb_slave_memory_pkg;

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int unsigned PROT_W      = 3;
    localparam int unsigned PROT_PRIV   = 0;
    localparam int unsigned PROT_NONSEC = 1;
    localparam int unsigned PROT_INSTR  = 2;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {ERR_NONE, ERR_RANGE, ERR_PROT} err_code_t;

endpackage

// File: rtl/apb_slave_memory_if.sv
// APB4 bus signals between a requester and the slave memory.
interface apb_slave_memory_if
    import apb_slave_memory_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned A = 10,
    parameter int unsigned B = N / 8,
    parameter int unsigned O = 1
);
    logic [A-1:0]      paddr;
    logic [PROT_W-1:0] pprot;
    logic [O-1:0]      pselx;
    logic              penable;
    logic              pwrite;
    logic [N-1:0]      pwdata;
    logic [B-1:0]      pstrb;
    logic              pready;
    logic [N-1:0]      prdata;
    logic              pslverr;

    modport master (
        output paddr, pprot, pselx, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pprot, pselx, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_mem_bytelane_ram.sv
// D x N word RAM with per-byte write enables and one registered read port.
module apb_mem_bytelane_ram
    import apb_slave_memory_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned D = 1024,
    parameter int unsigned A = 10,
    parameter int unsigned B = N / 8
) (
    input  logic         clk_i,
    input  logic         we_i,
    input  logic [B-1:0] be_i,
    input  logic         re_i,
    input  logic [A-1:0] addr_i,
    input  logic [N-1:0] wdata_i,
    output logic [N-1:0] rdata_o
);
    logic [N-1:0] mem_q [D];
    logic [N-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
        if (we_i) begin
            for (int unsigned b = 0; b < B; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][BYTE_W*b +: BYTE_W] <= wdata_i[BYTE_W*b +: BYTE_W];
                end
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/apb_slave_memory.sv
// Zero-wait-state APB4 completer around a byte-lane RAM.
// Define APB_SLV_MEM_PROT_CHECK_EN to reject non-secure (pprot[1]) transfers with pslverr.
module apb_slave_memory
    import apb_slave_memory_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned D = 1024,
    parameter int unsigned A = $clog2(D),
    parameter int unsigned B = N / 8,
    parameter int unsigned O = 1,
    parameter int unsigned I = 0
) (
    input logic                pclk,
    input logic                presetn,
    apb_slave_memory_if.slave  apb
);
    state_t    state_d, state_q;
    logic      pready_d, pready_q;
    logic      pslverr_d, pslverr_q;
    logic      rd_valid_d, rd_valid_q;
    err_code_t err_code;
    logic      sel, setup, err, addr_oob;
    logic      ram_we;
    logic [N-1:0] ram_rdata;

    // A power-of-two depth covers the whole address space, so no range error exists.
    if (D == (1 << A)) begin : g_no_range
        assign addr_oob = 1'b0;
    end else begin : g_range
        assign addr_oob = (32'(apb.paddr) >= D);
    end

    always_comb begin
        err_code = ERR_NONE;
        if (addr_oob) begin
            err_code = ERR_RANGE;
        end
`ifdef APB_SLV_MEM_PROT_CHECK_EN
        else if (apb.pprot[PROT_NONSEC]) begin
            err_code = ERR_PROT;
        end
`endif
    end

    always_comb begin
        sel        = apb.pselx[I];
        setup      = sel & ~apb.penable;
        err        = (err_code != ERR_NONE);
        state_d    = IDLE;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        rd_valid_d = 1'b0;
        ram_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (setup) state_d = ACCESS;
            end
            ACCESS: begin
                if (setup) state_d = ACCESS;
                ram_we = sel & apb.penable & apb.pwrite & pready_q & ~err;
            end
            default: state_d = IDLE;
        endcase
        // Outputs for the ACCESS cycle are captured while SETUP is on the bus.
        if (setup) begin
            pready_d   = 1'b1;
            pslverr_d  = err;
            rd_valid_d = ~apb.pwrite & ~err;
        end
    end

    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            state_q    <= IDLE;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    apb_mem_bytelane_ram #(
        .N (N),
        .D (D),
        .A (A),
        .B (B)
    ) u_ram (
        .clk_i   (pclk),
        .we_i    (ram_we),
        .be_i    (apb.pstrb),
        .re_i    (rd_valid_d),
        .addr_i  (apb.paddr),
        .wdata_i (apb.pwdata),
        .rdata_o (ram_rdata)
    );

    // RAM output register is not reset; the registered valid flag masks it to zero.
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = rd_valid_q ? ram_rdata : '0;
endmodule

// File: tb/tb_apb_slave_memory.sv
// Self-checking bench for apb_slave_memory against a byte-array reference model.
module tb_apb_slave_memory;
    localparam int unsigned N = 32;
    localparam int unsigned D = 1024;
    localparam int unsigned A = 10;
    localparam int unsigned B = 4;
    localparam int unsigned O = 1;

    logic pclk    = 1'b0;
    logic presetn = 1'b1;
    int   tests   = 0;
    int   fails   = 0;

    logic [7:0] mb [D][B];

    apb_slave_memory_if #(.N(N), .A(A), .B(B), .O(O)) bus ();

    apb_slave_memory #(
        .N (N),
        .D (D),
        .A (A),
        .B (B),
        .O (O),
        .I (0)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .apb     (bus)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pready"}, {31'b0, bus.pready}, 32'd0);
        chk({tag, "_pslverr"}, {31'b0, bus.pslverr}, 32'd0);
        chk({tag, "_prdata"}, bus.prdata, 32'd0);
    endtask

    function automatic logic [31:0] model_word(input logic [9:0] a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = mb[a][b];
        return w;
    endfunction

    function automatic bit prot_err(input logic [2:0] p);
`ifdef APB_SLV_MEM_PROT_CHECK_EN
        return p[1];
`else
        return (p === 3'bxxx);
`endif
    endfunction

    task automatic do_xfer(input bit wr, input logic [9:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p, input string tag,
                           output logic [31:0] rd);
        bit          err;
        logic [31:0] exp;
        err = prot_err(p);
        exp = (!wr && !err) ? model_word(a) : 32'h0;
        @(posedge pclk); #1;
        bus.pselx   = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = a;
        bus.pwdata  = d;
        bus.pstrb   = s;
        bus.pprot   = p;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        #1;
        chk({tag, "_pready"}, {31'b0, bus.pready}, 32'd1);
        chk({tag, "_pslverr"}, {31'b0, bus.pslverr}, {31'b0, err});
        chk({tag, "_prdata"}, bus.prdata, exp);
        rd = bus.prdata;
        if (wr && !err) begin
            for (int b = 0; b < 4; b++) if (s[b]) mb[a][b] = d[8*b +: 8];
        end
    endtask

    task automatic go_idle(input string tag);
        @(posedge pclk); #1;
        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
        #1;
        chk_idle(tag);
    endtask

    initial begin
        logic [31:0] rd;
        logic [9:0]  pool [8];

        bus.pselx   = '0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        bus.pstrb   = '0;
        bus.pprot   = '0;

        // Reset held for 5 clocks, then released at 50 ns.
        repeat (5) @(posedge pclk);
        #1 chk_idle("in_reset");
        #4 presetn = 1'b0;
        repeat (3) @(posedge pclk);
        #1 chk_idle("post_reset");

        // Full write then read.
        do_xfer(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 3'b000, "wr_010", rd);
        go_idle("wr_010_exit");
        do_xfer(1'b0, 10'h010, 32'h0, 4'h0, 3'b000, "rd_010", rd);
        chk("rd_010_lit", rd, 32'hDEADBEEF);
        go_idle("rd_010_exit");

        // Byte strobes, including an all-zero strobe no-op write.
        do_xfer(1'b1, 10'd5, 32'h11223344, 4'hF, 3'b000, "wr5_full", rd);
        go_idle("wr5_full_exit");
        do_xfer(1'b1, 10'd5, 32'hAABBCCDD, 4'b0101, 3'b000, "wr5_part", rd);
        go_idle("wr5_part_exit");
        do_xfer(1'b1, 10'd5, 32'hFFFFFFFF, 4'b0000, 3'b000, "wr5_nostrb", rd);
        go_idle("wr5_nostrb_exit");
        do_xfer(1'b0, 10'd5, 32'h0, 4'hF, 3'b000, "rd5", rd);
        chk("rd5_lit", rd, 32'h11BB33DD);
        go_idle("rd5_exit");

        // Back-to-back transfers with no idle cycle in between.
        do_xfer(1'b1, 10'h000, 32'h600DCAFE, 4'hF, 3'b000, "b2b_wr0", rd);
        do_xfer(1'b1, 10'h3FF, 32'h0000FFFF, 4'hF, 3'b000, "b2b_wr3ff", rd);
        do_xfer(1'b0, 10'h3FF, 32'h0, 4'h0, 3'b000, "b2b_rd3ff", rd);
        chk("b2b_rd3ff_lit", rd, 32'h0000FFFF);
        do_xfer(1'b0, 10'h000, 32'h0, 4'h0, 3'b000, "b2b_rd0", rd);
        chk("b2b_rd0_lit", rd, 32'h600DCAFE);
        go_idle("b2b_exit");

        // Deselected bus activity must not touch memory.
        do_xfer(1'b1, 10'd7, 32'hCAFEF00D, 4'hF, 3'b000, "wr7", rd);
        go_idle("wr7_exit");
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk); #1;
            bus.pselx   = 1'b0;
            bus.penable = i[0];
            bus.pwrite  = 1'b1;
            bus.paddr   = 10'd7;
            bus.pwdata  = 32'h12345678;
            bus.pstrb   = 4'hF;
            #1 chk_idle("desel");
        end
        go_idle("desel_exit");
        do_xfer(1'b0, 10'd7, 32'h0, 4'h0, 3'b000, "rd7", rd);
        chk("rd7_lit", rd, 32'hCAFEF00D);
        go_idle("rd7_exit");

        // ACCESS without SETUP is ignored.
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            bus.pselx   = 1'b1;
            bus.penable = 1'b1;
            bus.pwrite  = 1'b1;
            bus.paddr   = 10'd7;
            bus.pwdata  = 32'h87654321;
            #1 chk_idle("no_setup");
        end
        go_idle("no_setup_exit");
        do_xfer(1'b0, 10'd7, 32'h0, 4'h0, 3'b000, "rd7_b", rd);
        chk("rd7_b_lit", rd, 32'hCAFEF00D);
        go_idle("rd7_b_exit");

        // Reset during ACCESS clears outputs at once and drops the write.
        do_xfer(1'b1, 10'd3, 32'h01020304, 4'hF, 3'b000, "wr3", rd);
        go_idle("wr3_exit");
        @(posedge pclk); #1;
        bus.pselx  = 1'b1;
        bus.pwrite = 1'b1;
        bus.paddr  = 10'd3;
        bus.pwdata = 32'hFEEDFACE;
        bus.pstrb  = 4'hF;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        #1 presetn  = 1'b1;
        #1 chk_idle("mid_reset");
        @(posedge pclk); #1;
        presetn     = 1'b0;
        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
        do_xfer(1'b0, 10'd3, 32'h0, 4'h0, 3'b000, "rd3", rd);
        chk("rd3_lit", rd, 32'h01020304);
        go_idle("rd3_exit");

        // Non-secure access: rejected only when the protection check is built in.
        do_xfer(1'b1, 10'd2, 32'h5A5A5A5A, 4'hF, 3'b000, "wr2", rd);
        go_idle("wr2_exit");
        do_xfer(1'b1, 10'd2, 32'h0BADF00D, 4'hF, 3'b010, "wr2_nonsec", rd);
        go_idle("wr2_nonsec_exit");
        do_xfer(1'b0, 10'd2, 32'h0, 4'h0, 3'b000, "rd2", rd);
`ifdef APB_SLV_MEM_PROT_CHECK_EN
        chk("rd2_lit", rd, 32'h5A5A5A5A);
`else
        chk("rd2_lit", rd, 32'h0BADF00D);
`endif
        go_idle("rd2_exit");
        do_xfer(1'b1, 10'd2, 32'h13572468, 4'hF, 3'b000, "wr2_sec", rd);
        go_idle("wr2_sec_exit");
        do_xfer(1'b0, 10'd2, 32'h0, 4'h0, 3'b000, "rd2_sec", rd);
        chk("rd2_sec_lit", rd, 32'h13572468);
        go_idle("rd2_sec_exit");

        // Randomised traffic over a small pool of initialised addresses.
        for (int i = 0; i < 8; i++) begin
            pool[i] = 10'($urandom_range(0, D - 1));
            do_xfer(1'b1, pool[i], $urandom, 4'hF, 3'b000, "rnd_init", rd);
        end
        go_idle("rnd_init_exit");
        for (int i = 0; i < 60; i++) begin
            do_xfer(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom,
                    4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), "rnd", rd);
            if ($urandom_range(0, 1) == 1) go_idle("rnd_exit");
        end
        go_idle("rnd_final_exit");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
